uart_rx_core: RTL and testbench

- Parametrised UART receiver: configurable data width, parity and stop bits; mid-bit sampling.
- Delivers received frames on a valid/ready stream with per-frame error sideband, overrun and break reporting.
- Sits between the board-level uart_rx pin and the command/decode logic inside top_level.
- Supersedes the fixed 8N1 receive path.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx_core.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, parity modes and
// a parity helper sized for the widest supported data word.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_DELIVER = 3'd5,
    ST_BRK     = 3'd6
  } rx_state_t;

  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an idle-high asynchronous line; both stages
// come out of reset at 1 so no spurious falling edge is seen after reset.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // metastability capture followed by the settled stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with mid-bit sampling, valid/ready output stream,
// per-frame parity/framing sideband, and overrun/break pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_parity_err,
  output logic                 m_frame_err,
  output logic                 overrun,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_WANT  = (PARITY == PAR_ODD) ? 1'b1 : 1'b0;

  logic                 rx_s;
  logic                 sample_s;
  rx_state_t            state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic [DATA_BITS-1:0] m_data_q;
  logic                 m_valid_q;
  logic                 m_parity_err_q;
  logic                 m_frame_err_q;
  logic                 overrun_q;
  logic                 break_q;
  logic                 busy_q;

  uart_sync2 u_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (uart_rx),
    .q_o    (rx_s)
  );

  assign sample_s = (bit_cnt_q == CNT_LAST);

  // receive FSM, bit timing and the registered output stream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= {CNT_W{1'b0}};
      idx_q          <= {IDX_W{1'b0}};
      shift_q        <= {DATA_BITS{1'b0}};
      par_err_q      <= 1'b0;
      frm_err_q      <= 1'b0;
      m_data_q       <= {DATA_BITS{1'b0}};
      m_valid_q      <= 1'b0;
      m_parity_err_q <= 1'b0;
      m_frame_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
      break_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
      if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= {CNT_W{1'b0}};
          if (!rx_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_cnt_q == CNT_HALF) begin
            bit_cnt_q <= {CNT_W{1'b0}};
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              idx_q     <= {IDX_W{1'b0}};
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end
        ST_DATA: begin
          if (sample_s) begin
            bit_cnt_q <= {CNT_W{1'b0}};
            // LSB arrives first, so shifting in at the top leaves it at bit 0
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (idx_q == DATA_LAST) begin
              idx_q   <= {IDX_W{1'b0}};
              state_q <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end
        ST_PARITY: begin
          if (sample_s) begin
            bit_cnt_q <= {CNT_W{1'b0}};
            par_err_q <= (parity_of(MAX_DATA_BITS'(shift_q)) ^ rx_s) != PAR_WANT;
            state_q   <= ST_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end
        ST_STOP: begin
          if (sample_s) begin
            bit_cnt_q <= {CNT_W{1'b0}};
            if (!rx_s) begin
              frm_err_q <= 1'b1;
            end
            if (idx_q == STOP_LAST) begin
              idx_q   <= {IDX_W{1'b0}};
              state_q <= ST_DELIVER;
            end else begin
              idx_q <= idx_q + IDX_ONE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_ONE;
          end
        end
        ST_DELIVER: begin
          // a simultaneous accept frees the slot, so the new frame still loads
          if (m_valid_q && !m_ready) begin
            overrun_q <= 1'b1;
          end else begin
            m_data_q       <= shift_q;
            m_parity_err_q <= par_err_q;
            m_frame_err_q  <= frm_err_q;
            m_valid_q      <= 1'b1;
          end
          break_q <= frm_err_q && (shift_q == {DATA_BITS{1'b0}});
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_BRK;
          end
        end
        ST_BRK: begin
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_data       = m_data_q;
  assign m_valid      = m_valid_q;
  assign m_parity_err = m_parity_err_q;
  assign m_frame_err  = m_frame_err_q;
  assign overrun      = overrun_q;
  assign break_det    = break_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and an 8E1 instance driven
// from a frame table, plus hand sequences for glitch, overrun, break and reset.
module tb_uart_rx_core;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       m_ready0 = 1'b1, m_ready1 = 1'b1;
  logic [7:0] m_data0, m_data1;
  logic       m_valid0, m_valid1;
  logic       perr0, perr1, ferr0, ferr1;
  logic       ovr0, ovr1, brk0, brk1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;

  int         cyc = 0;
  int         acc0 = 0, acc1 = 0, ovr_cnt0 = 0, brk_cnt0 = 0, ovr_cnt1 = 0, brk_cnt1 = 0;
  logic [7:0] cap_data0 = 8'h00, cap_data1 = 8'h00;
  logic       cap_perr0 = 1'b0, cap_perr1 = 1'b0, cap_ferr0 = 1'b0, cap_ferr1 = 1'b0;
  int         cap_cyc0 = 0, cap_cyc1 = 0;
  int         t_start = 0;

  always #5 clk = ~clk;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .uart_rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready0), .m_parity_err(perr0), .m_frame_err(ferr0), .overrun(ovr0),
    .break_det(brk0), .busy(busy0)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .uart_rx(rx1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_parity_err(perr1), .m_frame_err(ferr1), .overrun(ovr1),
    .break_det(brk1), .busy(busy1)
  );

  // stream monitor: records every accepted frame and counts pulses
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid0 && m_ready0) begin
      acc0 <= acc0 + 1; cap_data0 <= m_data0; cap_perr0 <= perr0; cap_ferr0 <= ferr0; cap_cyc0 <= cyc;
    end
    if (m_valid1 && m_ready1) begin
      acc1 <= acc1 + 1; cap_data1 <= m_data1; cap_perr1 <= perr1; cap_ferr1 <= ferr1; cap_cyc1 <= cyc;
    end
    if (ovr0) ovr_cnt0 <= ovr_cnt0 + 1;
    if (brk0) brk_cnt0 <= brk_cnt0 + 1;
    if (ovr1) ovr_cnt1 <= ovr_cnt1 + 1;
    if (brk1) brk_cnt1 <= brk_cnt1 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic sel, input logic v, input int n);
    if (sel) rx1 = v; else rx0 = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                            input logic par, input logic stop);
    t_start = cyc;
    drive_bit(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], CPB);
    if (has_par) drive_bit(sel, par, CPB);
    drive_bit(sel, stop, CPB);
    drive_bit(sel, 1'b1, 0);
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic       has_par;
    logic       par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_brk;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int a0, b0, o0, a1, b1, o1, bc;

    vecs[0] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 99};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 99};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 99};
    vecs[3] = '{1'b0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 99};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 99};
    vecs[5] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 109};
    vecs[6] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 109};
    vecs[7] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 109};
    vecs[8] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 109};

    repeat (3) @(negedge clk);
    check("rst_valid0", {31'd0, m_valid0}, 32'd0);
    check("rst_data0", {24'd0, m_data0}, 32'd0);
    check("rst_flags0", {27'd0, perr0, ferr0, ovr0, brk0, busy0}, 32'd0);
    check("rst_flags1", {26'd0, m_valid1, perr1, ferr1, ovr1, brk1, busy1}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      a0 = acc0; b0 = brk_cnt0; o0 = ovr_cnt0; a1 = acc1; b1 = brk_cnt1; o1 = ovr_cnt1;
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].has_par, vecs[i].par, vecs[i].stop);
      repeat (2 * CPB) @(negedge clk);
      if (vecs[i].sel) begin
        check($sformatf("v%0d_count", i), acc1 - a1, 32'd1);
        check($sformatf("v%0d_data", i), {24'd0, cap_data1}, {24'd0, vecs[i].data});
        check($sformatf("v%0d_perr", i), {31'd0, cap_perr1}, {31'd0, vecs[i].exp_perr});
        check($sformatf("v%0d_ferr", i), {31'd0, cap_ferr1}, {31'd0, vecs[i].exp_ferr});
        check($sformatf("v%0d_brk", i), brk_cnt1 - b1, {31'd0, vecs[i].exp_brk});
        check($sformatf("v%0d_ovr", i), ovr_cnt1 - o1, 32'd0);
        check($sformatf("v%0d_lat", i), cap_cyc1 - t_start, vecs[i].exp_lat);
      end else begin
        check($sformatf("v%0d_count", i), acc0 - a0, 32'd1);
        check($sformatf("v%0d_data", i), {24'd0, cap_data0}, {24'd0, vecs[i].data});
        check($sformatf("v%0d_perr", i), {31'd0, cap_perr0}, {31'd0, vecs[i].exp_perr});
        check($sformatf("v%0d_ferr", i), {31'd0, cap_ferr0}, {31'd0, vecs[i].exp_ferr});
        check($sformatf("v%0d_brk", i), brk_cnt0 - b0, {31'd0, vecs[i].exp_brk});
        check($sformatf("v%0d_ovr", i), ovr_cnt0 - o0, 32'd0);
        check($sformatf("v%0d_lat", i), cap_cyc0 - t_start, vecs[i].exp_lat);
      end
    end

    // short low glitch must be rejected as a false start
    a0 = acc0; bc = 0;
    drive_bit(1'b0, 1'b0, 4);
    rx0 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy0) bc++;
    end
    check("glitch_busy_le7", {31'd0, (bc >= 1) && (bc <= 7)}, 32'd1);
    check("glitch_no_frame", acc0 - a0, 32'd0);
    check("glitch_idle", {31'd0, busy0}, 32'd0);

    // second frame arrives while the first is still unaccepted
    m_ready0 = 1'b0;
    a0 = acc0; o0 = ovr_cnt0;
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    send_frame(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("ovr_valid_held", {31'd0, m_valid0}, 32'd1);
    check("ovr_data_held", {24'd0, m_data0}, 32'h12);
    check("ovr_pulse_once", ovr_cnt0 - o0, 32'd1);
    check("ovr_not_accepted", acc0 - a0, 32'd0);
    m_ready0 = 1'b1;
    @(negedge clk);
    check("ovr_accept_count", acc0 - a0, 32'd1);
    check("ovr_accept_data", {24'd0, cap_data0}, 32'h12);
    check("ovr_valid_drop", {31'd0, m_valid0}, 32'd0);

    // line held low for 30 bit times
    a0 = acc0; b0 = brk_cnt0;
    drive_bit(1'b0, 1'b0, 30 * CPB);
    check("brk_count", acc0 - a0, 32'd1);
    check("brk_data", {24'd0, cap_data0}, 32'd0);
    check("brk_ferr", {31'd0, cap_ferr0}, 32'd1);
    check("brk_pulse", brk_cnt0 - b0, 32'd1);
    check("brk_busy_low", {31'd0, busy0}, 32'd1);
    drive_bit(1'b0, 1'b1, 3 * CPB);
    check("brk_no_more", acc0 - a0, 32'd1);
    check("brk_idle", {31'd0, busy0}, 32'd0);

    // reset in the middle of data bit 4 with a frame pending on the output
    m_ready0 = 1'b0;
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    check("mid_pending", {31'd0, m_valid0}, 32'd1);
    drive_bit(1'b0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, CPB);
    drive_bit(1'b0, 1'b1, CPB / 2);
    check("mid_busy", {31'd0, busy0}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, m_valid0}, 32'd0);
    check("mid_rst_data", {24'd0, m_data0}, 32'd0);
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_ready0 = 1'b1;
    repeat (5) @(negedge clk);
    a0 = acc0;
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("post_rst_count", acc0 - a0, 32'd1);
    check("post_rst_data", {24'd0, cap_data0}, 32'hC3);
    check("post_rst_flags", {30'd0, cap_perr0, cap_ferr0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
